// File: rtl/run_ctrl.sv
// run_ctrl: sequences one simulation run: it holds the cores in reset, lets them run until
// all halt, drains, then reports completion. Define RUN_CTRL_WATCHDOG_EN to enable the TIMEOUT watchdog.
module run_ctrl #(
  parameter int NCORE = 1,
  parameter int CNT_W = 32,
  parameter int RST_CYC = 2,
  parameter int DRAIN_CYC = 1,
  parameter logic [CNT_W-1:0] TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NCORE-1:0] halt,
  output logic             core_rst,
  output logic             run,
  output logic [NCORE-1:0] halted_mask,
  output logic [CNT_W-1:0] cycles,
  output logic             exit,
  output logic             timeout,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] RST_LAST   = 8'(RST_CYC - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

  state_t     state_r;
  state_t     state_next;
  logic [7:0] sub_cnt;
  logic       accept;
  logic       active;
  logic       all_halted;
  logic       wd_hit;
  logic       wd_fire;

  assign active     = (state_r == RUN) || (state_r == DRAIN);
  assign all_halted = &(halted_mask | halt);

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = TIMEOUT - CNT_W'(1);

  assign wd_hit = (cycles == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if (accept) begin
      timeout <= 1'b0;
    end else if (wd_fire) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // A halt arriving on the watchdog cycle takes priority, so a run that just made it is not flagged.
  always_comb begin
    state_next = state_r;
    accept     = 1'b0;
    wd_fire    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next = RESET;
          accept     = 1'b1;
        end
      end
      RESET: begin
        if (sub_cnt == RST_LAST) state_next = RUN;
      end
      RUN: begin
        if (all_halted) begin
          state_next = (DRAIN_CYC == 0) ? DONE : DRAIN;
        end else if (wd_hit) begin
          state_next = DONE;
          wd_fire    = 1'b1;
        end
      end
      DRAIN: begin
        if (wd_hit) begin
          state_next = DONE;
          wd_fire    = 1'b1;
        end else if (sub_cnt == DRAIN_LAST) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The cycle count freezes on the watchdog cycle itself, leaving it at TIMEOUT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      sub_cnt     <= '0;
      cycles      <= '0;
      halted_mask <= '0;
    end else begin
      state_r <= state_next;
      if (accept) begin
        sub_cnt     <= '0;
        cycles      <= '0;
        halted_mask <= '0;
      end else begin
        if (state_next != state_r) begin
          sub_cnt <= '0;
        end else if ((state_r == RESET) || (state_r == DRAIN)) begin
          sub_cnt <= sub_cnt + 8'd1;
        end
        if (active) begin
          halted_mask <= halted_mask | halt;
          if (!wd_fire && (cycles != '1)) cycles <= cycles + CNT_W'(1);
        end
      end
    end
  end

  assign state    = state_r;
  assign core_rst = (state_r == RUN) || (state_r == DRAIN) || (state_r == DONE);
  assign run      = active;
  assign exit     = (state_r == DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl; a 4-core instance covers the main sequences and a
// narrow-counter, zero-drain instance covers saturation and the direct RUN->DONE path.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  halt;
  logic        core_rst;
  logic        run;
  logic [3:0]  halted_mask;
  logic [15:0] cycles;
  logic        exit;
  logic        timeout;
  logic [2:0]  state;

  logic        start_b;
  logic [0:0]  halt_b;
  logic        core_rst_b;
  logic        run_b;
  logic [0:0]  halted_mask_b;
  logic [3:0]  cycles_b;
  logic        exit_b;
  logic        timeout_b;
  logic [2:0]  state_b;

  int tests_run = 0;
  int tests_failed = 0;

  run_ctrl #(
    .NCORE(4), .CNT_W(16), .RST_CYC(2), .DRAIN_CYC(1), .TIMEOUT(16'd20)
  ) u_main (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .core_rst(core_rst), .run(run), .halted_mask(halted_mask), .cycles(cycles),
    .exit(exit), .timeout(timeout), .state(state)
  );

  run_ctrl #(
    .NCORE(1), .CNT_W(4), .RST_CYC(1), .DRAIN_CYC(0), .TIMEOUT(4'd15)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start_b), .halt(halt_b),
    .core_rst(core_rst_b), .run(run_b), .halted_mask(halted_mask_b), .cycles(cycles_b),
    .exit(exit_b), .timeout(timeout_b), .state(state_b)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    halt = '0;
    start_b = 1'b0;
    halt_b = '0;

    // Power-on reset applied between clock edges
    #2 rst = 1'b0;
    #1;
    check_output("por_state", 32'(state), 32'd0);
    check_output("por_core_rst", 32'(core_rst), 32'd0);
    check_output("por_run", 32'(run), 32'd0);
    check_output("por_exit", 32'(exit), 32'd0);
    check_output("por_timeout", 32'(timeout), 32'd0);
    check_output("por_cycles", 32'(cycles), 32'd0);
    check_output("por_mask", 32'(halted_mask), 32'd0);
    step(2);
    rst = 1'b1;
    step(3);
    check_output("idle_after_release", 32'(state), 32'd0);
    check_output("idle_core_rst", 32'(core_rst), 32'd0);

    // Run 1: all cores halt after 10 RUN cycles
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_output("r1_reset_state", 32'(state), 32'd1);
    check_output("r1_reset_core_rst", 32'(core_rst), 32'd0);
    step(1);
    check_output("r1_reset_second", 32'(state), 32'd1);
    check_output("r1_reset_core_rst2", 32'(core_rst), 32'd0);
    step(1);
    check_output("r1_run_state", 32'(state), 32'd2);
    check_output("r1_run_core_rst", 32'(core_rst), 32'd1);
    check_output("r1_run_flag", 32'(run), 32'd1);
    check_output("r1_run_cycles0", 32'(cycles), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) start = 1'b1;
      if (i == 6) start = 1'b0;
      step(1);
    end
    check_output("r1_cycles10", 32'(cycles), 32'd10);
    check_output("r1_start_ignored", 32'(state), 32'd2);
    halt = 4'hF;
    step(1);
    halt = 4'h0;
    check_output("r1_drain_state", 32'(state), 32'd3);
    check_output("r1_drain_cycles", 32'(cycles), 32'd11);
    check_output("r1_drain_mask", 32'(halted_mask), 32'hF);
    check_output("r1_drain_run", 32'(run), 32'd1);
    step(1);
    check_output("r1_done_state", 32'(state), 32'd4);
    check_output("r1_done_exit", 32'(exit), 32'd1);
    check_output("r1_done_run", 32'(run), 32'd0);
    check_output("r1_done_core_rst", 32'(core_rst), 32'd1);
    check_output("r1_done_timeout", 32'(timeout), 32'd0);
    check_output("r1_done_cycles", 32'(cycles), 32'd12);
    step(3);
    check_output("r1_done_persist", 32'(state), 32'd4);
    check_output("r1_cycles_frozen", 32'(cycles), 32'd12);

    // Run 2: restart from DONE, staggered one-cycle halt pulses
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_output("r2_reset_state", 32'(state), 32'd1);
    check_output("r2_cycles_clear", 32'(cycles), 32'd0);
    check_output("r2_mask_clear", 32'(halted_mask), 32'd0);
    check_output("r2_exit_clear", 32'(exit), 32'd0);
    halt = 4'b0001;
    step(1);
    halt = 4'b0000;
    check_output("r2_halt_in_reset", 32'(halted_mask), 32'd0);
    step(1);
    check_output("r2_run_state", 32'(state), 32'd2);
    step(2);
    for (int b = 0; b < 4; b++) begin
      halt = 4'(1 << b);
      step(1);
      halt = 4'b0000;
      check_output("r2_mask_step", 32'(halted_mask), 32'((1 << (b + 1)) - 1));
      if (b < 3) begin
        step(1);
        check_output("r2_mask_sticky", 32'(halted_mask), 32'((1 << (b + 1)) - 1));
        check_output("r2_still_run", 32'(state), 32'd2);
      end
    end
    check_output("r2_drain_state", 32'(state), 32'd3);
    check_output("r2_drain_cycles", 32'(cycles), 32'd9);
    step(1);
    check_output("r2_done_state", 32'(state), 32'd4);
    check_output("r2_done_cycles", 32'(cycles), 32'd10);

    // Run 3: no halt at all
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    check_output("r3_run_state", 32'(state), 32'd2);
    step(19);
    check_output("r3_cycles19", 32'(cycles), 32'd19);
    check_output("r3_run_at_19", 32'(state), 32'd2);
    step(1);
`ifdef RUN_CTRL_WATCHDOG_EN
    check_output("r3_wd_state", 32'(state), 32'd4);
    check_output("r3_wd_timeout", 32'(timeout), 32'd1);
    check_output("r3_wd_exit", 32'(exit), 32'd1);
    check_output("r3_wd_cycles", 32'(cycles), 32'd19);
    step(2);
    check_output("r3_wd_frozen", 32'(cycles), 32'd19);
    check_output("r3_wd_timeout_held", 32'(timeout), 32'd1);
`else
    check_output("r3_nowd_state", 32'(state), 32'd2);
    check_output("r3_nowd_cycles", 32'(cycles), 32'd20);
    check_output("r3_nowd_timeout", 32'(timeout), 32'd0);
    halt = 4'hF;
    step(1);
    halt = 4'h0;
    check_output("r3_nowd_drain", 32'(state), 32'd3);
    step(1);
    check_output("r3_nowd_done", 32'(state), 32'd4);
    check_output("r3_nowd_done_cycles", 32'(cycles), 32'd22);
    check_output("r3_nowd_done_timeout", 32'(timeout), 32'd0);
`endif

    // Run 4: all halted on the would-be watchdog cycle
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_output("r4_timeout_clear", 32'(timeout), 32'd0);
    step(2);
    step(19);
    check_output("r4_cycles19", 32'(cycles), 32'd19);
    halt = 4'hF;
    step(1);
    halt = 4'h0;
    check_output("r4_drain_state", 32'(state), 32'd3);
    check_output("r4_drain_timeout", 32'(timeout), 32'd0);
    check_output("r4_drain_cycles", 32'(cycles), 32'd20);
    step(1);
    check_output("r4_done_state", 32'(state), 32'd4);
    check_output("r4_done_timeout", 32'(timeout), 32'd0);
    check_output("r4_done_cycles", 32'(cycles), 32'd21);

    // Run 5: asynchronous reset in the middle of RUN
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    step(5);
    check_output("r5_cycles5", 32'(cycles), 32'd5);
    #3 rst = 1'b0;
    #1;
    check_output("r5_rst_state", 32'(state), 32'd0);
    check_output("r5_rst_core_rst", 32'(core_rst), 32'd0);
    check_output("r5_rst_run", 32'(run), 32'd0);
    check_output("r5_rst_exit", 32'(exit), 32'd0);
    check_output("r5_rst_cycles", 32'(cycles), 32'd0);
    check_output("r5_rst_mask", 32'(halted_mask), 32'd0);
    check_output("r5_rst_timeout", 32'(timeout), 32'd0);
    #2 rst = 1'b1;
    step(2);
    check_output("r5_idle_state", 32'(state), 32'd0);
    check_output("r5_idle_cycles", 32'(cycles), 32'd0);

    // Narrow instance: zero drain goes straight to DONE
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    check_output("b1_reset_state", 32'(state_b), 32'd1);
    check_output("b1_reset_core_rst", 32'(core_rst_b), 32'd0);
    step(1);
    check_output("b1_run_state", 32'(state_b), 32'd2);
    check_output("b1_run_cycles", 32'(cycles_b), 32'd0);
    step(3);
    halt_b = 1'b1;
    step(1);
    halt_b = 1'b0;
    check_output("b1_done_direct", 32'(state_b), 32'd4);
    check_output("b1_done_cycles", 32'(cycles_b), 32'd4);
    check_output("b1_done_mask", 32'(halted_mask_b), 32'd1);
    check_output("b1_done_timeout", 32'(timeout_b), 32'd0);

    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    check_output("b2_mask_clear", 32'(halted_mask_b), 32'd0);
    step(1);
    step(14);
    check_output("b2_cycles14", 32'(cycles_b), 32'd14);
    check_output("b2_run_state", 32'(state_b), 32'd2);
    step(1);
`ifdef RUN_CTRL_WATCHDOG_EN
    check_output("b2_wd_state", 32'(state_b), 32'd4);
    check_output("b2_wd_timeout", 32'(timeout_b), 32'd1);
    check_output("b2_wd_cycles", 32'(cycles_b), 32'd14);
`else
    check_output("b2_cycles15", 32'(cycles_b), 32'd15);
    check_output("b2_still_run", 32'(state_b), 32'd2);
    step(5);
    check_output("b2_saturated", 32'(cycles_b), 32'd15);
    halt_b = 1'b1;
    step(1);
    halt_b = 1'b0;
    check_output("b2_done_state", 32'(state_b), 32'd4);
    check_output("b2_done_cycles", 32'(cycles_b), 32'd15);
    check_output("b2_done_timeout", 32'(timeout_b), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
